// File: rtl/imu_avg_filter_pkg.sv
// Shared constants and FSM state encoding for the imu_avg_filter moving-average block.
package imu_avg_filter_pkg;

    localparam int AVG_N_DATA     = 36;
    localparam int AVG_DEPTH_LOG2 = 3;

    typedef enum logic [1:0] {
        AVG_IDLE  = 2'd0,
        AVG_FETCH = 2'd1,
        AVG_ACCUM = 2'd2,
        AVG_EMIT  = 2'd3
    } avg_state_t;

endpackage

// File: rtl/imu_avg_filter_avg_axis.sv
// One axis of the moving-average filter: sample buffer, running sum and scaled average.
module avg_axis
    import imu_avg_filter_pkg::*;
#(
    parameter int N_DATA     = AVG_N_DATA,
    parameter int DEPTH_LOG2 = AVG_DEPTH_LOG2
) (
    input  logic                     sys_clk,
    input  logic                     resetn,
    input  logic                     load,
    input  logic                     fetch,
    input  logic                     accum,
    input  logic                     window_full,
    input  logic [DEPTH_LOG2-1:0]    wr_ptr,
    input  logic signed [N_DATA-1:0] sample,
    output logic signed [N_DATA-1:0] avg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = N_DATA + DEPTH_LOG2;

    logic signed [N_DATA-1:0] mem_r [DEPTH];
    logic signed [N_DATA-1:0] new_r;
    logic signed [N_DATA-1:0] oldest_r;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [N_DATA-1:0] avg_r;
    logic signed [SUM_W-1:0]  sum_nxt_s;
    logic signed [SUM_W-1:0]  shift_s;

    // Next running sum and its floor-scaled average (arithmetic shift rounds toward -inf).
    always_comb begin
        sum_nxt_s = sum_r + {{DEPTH_LOG2{new_r[N_DATA-1]}}, new_r}
                          - {{DEPTH_LOG2{oldest_r[N_DATA-1]}}, oldest_r};
        shift_s   = sum_nxt_s >>> DEPTH_LOG2;
    end

    // Window storage; contents need no reset because unfilled slots read as zero.
    always_ff @(posedge sys_clk) begin
        if (accum) begin
            mem_r[wr_ptr] <= new_r;
        end
    end

    // Sample latch, oldest-entry fetch and sum/average update.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            new_r    <= {N_DATA{1'b0}};
            oldest_r <= {N_DATA{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            avg_r    <= {N_DATA{1'b0}};
        end else begin
            if (load) begin
                new_r <= sample;
            end
            if (fetch) begin
                oldest_r <= window_full ? mem_r[wr_ptr] : {N_DATA{1'b0}};
            end
            if (accum) begin
                sum_r <= sum_nxt_s;
                avg_r <= shift_s[N_DATA-1:0];
            end
        end
    end

    assign avg = avg_r;

endmodule

// File: rtl/imu_avg_filter.sv
// Three-axis streaming moving-average filter behind the imu block.
// Optional sticky overrun detection is built when IMU_AVG_OVERRUN_EN is defined.
module imu_avg_filter
    import imu_avg_filter_pkg::*;
#(
    parameter int N_DATA     = AVG_N_DATA,
    parameter int DEPTH_LOG2 = AVG_DEPTH_LOG2
) (
    input  logic                     sys_clk,
    input  logic                     resetn,
    input  logic                     sample_strobe,
    input  logic signed [N_DATA-1:0] x_in,
    input  logic signed [N_DATA-1:0] y_in,
    input  logic signed [N_DATA-1:0] z_in,
    output logic signed [N_DATA-1:0] x_avg,
    output logic signed [N_DATA-1:0] y_avg,
    output logic signed [N_DATA-1:0] z_avg,
    output logic                     avg_valid,
    output logic                     primed,
    output logic                     overrun
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int FILL_W = DEPTH_LOG2 + 1;

    avg_state_t              state_r, state_nxt_s;
    logic [DEPTH_LOG2-1:0]   wr_ptr_r;
    logic [FILL_W-1:0]       fill_r, fill_nxt_s;
    logic                    window_full_s;
    logic                    load_s, fetch_s, accum_s;
    logic                    avg_valid_r, primed_r;

    // State register.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= AVG_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; strobes outside IDLE are ignored.
    always_comb begin
        state_nxt_s = AVG_IDLE;
        case (state_r)
            AVG_IDLE:  state_nxt_s = sample_strobe ? AVG_FETCH : AVG_IDLE;
            AVG_FETCH: state_nxt_s = AVG_ACCUM;
            AVG_ACCUM: state_nxt_s = AVG_EMIT;
            AVG_EMIT:  state_nxt_s = AVG_IDLE;
            default:   state_nxt_s = AVG_IDLE;
        endcase
    end

    // Per-state datapath enables.
    always_comb begin
        load_s  = 1'b0;
        fetch_s = 1'b0;
        accum_s = 1'b0;
        case (state_r)
            AVG_IDLE:  load_s  = sample_strobe;
            AVG_FETCH: fetch_s = 1'b1;
            AVG_ACCUM: accum_s = 1'b1;
            AVG_EMIT:  load_s  = 1'b0;
            default:   load_s  = 1'b0;
        endcase
    end

    // Saturating fill count.
    always_comb begin
        window_full_s = (fill_r == FILL_W'(DEPTH));
        if (window_full_s) begin
            fill_nxt_s = fill_r;
        end else begin
            fill_nxt_s = fill_r + FILL_W'(1);
        end
    end

    // Pointer, fill and status outputs; valid/primed load on entry to EMIT so they
    // are visible during the EMIT cycle together with the new averages.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            avg_valid_r <= 1'b0;
            primed_r    <= 1'b0;
        end else begin
            avg_valid_r <= accum_s;
            if (accum_s) begin
                wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
                fill_r   <= fill_nxt_s;
                primed_r <= (fill_nxt_s == FILL_W'(DEPTH));
            end
        end
    end

`ifdef IMU_AVG_OVERRUN_EN
    logic overrun_r;

    // Sticky record of any strobe dropped while busy.
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            overrun_r <= 1'b0;
        end else if (sample_strobe && (state_r != AVG_IDLE)) begin
            overrun_r <= 1'b1;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = 1'b0;
`endif

    avg_axis #(.N_DATA(N_DATA), .DEPTH_LOG2(DEPTH_LOG2)) u_x (
        .sys_clk(sys_clk), .resetn(resetn), .load(load_s), .fetch(fetch_s),
        .accum(accum_s), .window_full(window_full_s), .wr_ptr(wr_ptr_r),
        .sample(x_in), .avg(x_avg)
    );

    avg_axis #(.N_DATA(N_DATA), .DEPTH_LOG2(DEPTH_LOG2)) u_y (
        .sys_clk(sys_clk), .resetn(resetn), .load(load_s), .fetch(fetch_s),
        .accum(accum_s), .window_full(window_full_s), .wr_ptr(wr_ptr_r),
        .sample(y_in), .avg(y_avg)
    );

    avg_axis #(.N_DATA(N_DATA), .DEPTH_LOG2(DEPTH_LOG2)) u_z (
        .sys_clk(sys_clk), .resetn(resetn), .load(load_s), .fetch(fetch_s),
        .accum(accum_s), .window_full(window_full_s), .wr_ptr(wr_ptr_r),
        .sample(z_in), .avg(z_avg)
    );

    assign avg_valid = avg_valid_r;
    assign primed    = primed_r;

endmodule
